// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit and receive paths.
//   uart_state_e : bit-timing FSM states
//   DATA_BITS    : payload bits per frame (8N1)
//   bps_cnt()    : sys_clk cycles per bit, truncated
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS = 8;

  function automatic int bps_cnt(input int clk_freq, input int bps);
    return clk_freq / bps;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with first-word fall-through read data.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter; level is the pointer difference.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   push, wdata        : write request (ignored while full)
//   pop, rdata         : read request (ignored while empty), head entry
//   full, empty, level : occupancy status
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign level = wr_ptr_q - rd_ptr_q;
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // A full FIFO refuses a push even when a pop happens on the same edge.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter, LSB first. Bytes enter a FIFO through a
// valid/ready handshake; the bit-timing FSM drains it onto uart_txd with
// back-to-back frames while data is queued.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   tx_valid, tx_data  : byte offer; accepted when tx_ready is 1
//   tx_ready           : FIFO not full
//   uart_txd           : registered serial line, idles high
//   tx_busy            : FIFO non-empty or a frame in progress
//   fifo_level         : FIFO occupancy
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for one bit period
// DATA  | eight payload bits, LSB first
// STOP  | stop bit (high); pops the next byte at its end if one is queued
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int UART_BPS   = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic                          uart_txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int          BPS_CNT  = bps_cnt(CLK_FREQ, UART_BPS);
  localparam logic [15:0] BIT_LAST = 16'(BPS_CNT - 1);
  localparam logic [2:0]  IDX_LAST = 3'(DATA_BITS - 1);

  if ((BPS_CNT < 2) || (BPS_CNT > 65535)) begin : g_bps_check
    $error("uart_tx_buf: CLK_FREQ/UART_BPS must lie in 2..65535");
  end

  uart_state_e          state_q, state_d;
  logic [15:0]          clk_cnt_q, clk_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 txd_q, txd_d;

  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 bit_done;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .push      (tx_valid),
    .pop       (fifo_pop),
    .wdata     (tx_data),
    .rdata     (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign bit_done = (clk_cnt_q == BIT_LAST);

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    fifo_pop  = 1'b0;
    // Every bit period restarts from zero; IDLE parks the counter at zero so
    // the first start bit is a full period.
    clk_cnt_d = ((state_q == IDLE) || bit_done) ? 16'd0 : clk_cnt_q + 16'd1;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          txd_d    = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (bit_done) begin
          txd_d     = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx_q != IDX_LAST) begin
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = shift_q[0];
            shift_d   = shift_q >> 1;
          end else begin
            txd_d   = 1'b1;
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          // Chain straight into the next start bit so frames have no gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            txd_d    = 1'b0;
            state_d  = START;
          end else begin
            txd_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
    end
  end

  assign uart_txd = txd_q;
  assign tx_ready = !fifo_full;
  assign tx_busy  = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_buf.sv
// Bench for uart_tx_buf at BPS_CNT=10, FIFO_DEPTH=8. A frame-position model
// predicts every output each cycle; a mid-bit serial decoder checks decoded
// bytes against the model's transmit order; directed phases pin literal
// timings and values.
module tb_uart_tx_buf;

  localparam int CLK_FREQ = 1000000;
  localparam int UART_BPS = 100000;
  localparam int DEPTH    = 8;
  localparam int B        = 10;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       tx_valid  = 1'b0;
  logic [7:0] tx_data   = 8'h00;
  logic       tx_ready;
  logic       uart_txd;
  logic       tx_busy;
  logic [3:0] fifo_level;

  always #5 sys_clk = ~sys_clk;

  uart_tx_buf #(
    .CLK_FREQ   (CLK_FREQ),
    .UART_BPS   (UART_BPS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .uart_txd   (uart_txd),
    .tx_busy    (tx_busy),
    .fifo_level (fifo_level)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: queued bytes plus the position (in cycles) inside the current frame.
  logic [7:0] m_q[$];
  logic [7:0] line_q[$];
  logic [7:0] m_cur = 8'h00;
  int         m_pos = -1;

  always @(posedge sys_clk or negedge sys_rst_n) begin : model
    logic acc;
    if (!sys_rst_n) begin
      m_q.delete();
      line_q.delete();
      m_pos = -1;
    end else begin
      acc = tx_valid && (m_q.size() < DEPTH);
      if (m_pos >= 0) begin
        m_pos++;
        if (m_pos == 10 * B) m_pos = -1;
      end
      if (m_pos < 0 && m_q.size() > 0) begin
        m_cur = m_q.pop_front();
        m_pos = 0;
        line_q.push_back(m_cur);
      end
      if (acc) m_q.push_back(tx_data);
    end
  end

  function automatic int exp_txd();
    int bitn;
    if (m_pos < 0) return 1;
    bitn = m_pos / B;
    if (bitn == 0) return 0;
    if (bitn == 9) return 1;
    return int'(m_cur[bitn-1]);
  endfunction

  always @(negedge sys_clk) begin
    chk("txd", int'(uart_txd), exp_txd());
    chk("ready", int'(tx_ready), (m_q.size() < DEPTH) ? 1 : 0);
    chk("busy", int'(tx_busy), ((m_pos >= 0) || (m_q.size() > 0)) ? 1 : 0);
    chk("level", int'(fifo_level), m_q.size());
  end

  // Serial decoder sampling at mid-bit.
  logic [7:0] dec_log[$];
  logic [7:0] dec_byte   = 8'h00;
  logic       dec_active = 1'b0;
  int         dec_cnt    = 0;

  always @(negedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dec_active = 1'b0;
      dec_cnt    = 0;
    end else if (!dec_active) begin
      if (uart_txd === 1'b0) begin
        dec_active = 1'b1;
        dec_cnt    = 0;
      end
    end else begin
      dec_cnt++;
      if (dec_cnt == B / 2) begin
        chk("start_mid", int'(uart_txd), 0);
      end else if ((dec_cnt % B == B / 2) && (dec_cnt / B <= 8)) begin
        dec_byte[dec_cnt / B - 1] = uart_txd;
      end else if (dec_cnt == 9 * B + B / 2) begin
        chk("stop_mid", int'(uart_txd), 1);
        dec_active = 1'b0;
        dec_log.push_back(dec_byte);
        if (line_q.size() == 0) chk("decode_unexpected", int'(dec_byte), -1);
        else chk("decode_byte", int'(dec_byte), int'(line_q.pop_front()));
      end
    end
  end

  // Low-run length monitor.
  int run_log[$];
  int run_len = 0;

  always @(negedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      run_len = 0;
    end else if (uart_txd === 1'b0) begin
      run_len++;
    end else if (run_len > 0) begin
      run_log.push_back(run_len);
      run_len = 0;
    end
  end

  function automatic int log_at(input int i);
    if (i < dec_log.size()) return int'(dec_log[i]);
    return -1;
  endfunction

  function automatic int run_at(input int i);
    if (i < run_log.size()) return run_log[i];
    return -1;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_byte(input logic [7:0] b, output int acc_cyc);
    logic ok;
    int   guard;
    guard    = 0;
    tx_valid = 1'b1;
    tx_data  = b;
    do begin
      ok = tx_ready;
      @(posedge sys_clk);
      @(negedge sys_clk);
      guard++;
    end while (!ok && guard < 2000);
    if (!ok) chk("push_timeout", 0, 1);
    acc_cyc = cyc;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge sys_clk);
  endtask

  task automatic wait_idle(input int budget);
    int g;
    g = 0;
    while ((tx_busy || m_pos >= 0 || m_q.size() > 0) && g < budget) begin
      @(negedge sys_clk);
      g++;
    end
    chk("idle_reached", int'(tx_busy), 0);
    repeat (3) @(negedge sys_clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, e2, n0, r0;
    int acc[10];
    int pat55[10];
    int div;
    pat55 = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};

    repeat (3) @(negedge sys_clk);
    chk("rst_txd", int'(uart_txd), 1);
    chk("rst_ready", int'(tx_ready), 1);
    chk("rst_busy", int'(tx_busy), 0);
    chk("rst_level", int'(fifo_level), 0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Single byte 0x55.
    n0 = dec_log.size();
    push_byte(8'h55, e);
    tx_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      wait_until(e + 5 + 10 * k);
      chk("b55_bit", int'(uart_txd), pat55[k]);
    end
    while (tx_busy && cyc < e + 300) @(negedge sys_clk);
    chk("b55_busy_fall", cyc - e, 101);
    chk("b55_decode", log_at(n0), 'h55);
    repeat (3) @(negedge sys_clk);

    // Back-to-back 0xA5, 0x3C.
    n0 = dec_log.size();
    push_byte(8'hA5, e);
    push_byte(8'h3C, e2);
    tx_valid = 1'b0;
    chk("b2b_consec", e2 - e, 1);
    while (tx_busy && cyc < e + 500) @(negedge sys_clk);
    chk("b2b_busy_fall", cyc - e, 201);
    chk("b2b_dec0", log_at(n0), 'hA5);
    chk("b2b_dec1", log_at(n0 + 1), 'h3C);
    repeat (3) @(negedge sys_clk);

    // Fill with 0x00..0x09, tx_valid held high.
    n0 = dec_log.size();
    for (int i = 0; i < 10; i++) begin
      push_byte(8'(i), acc[i]);
      if (i == 8) begin
        chk("fill_level8", int'(fifo_level), 8);
        chk("fill_ready0", int'(tx_ready), 0);
      end
    end
    tx_valid = 1'b0;
    chk("fill_acc8", acc[8] - acc[0], 8);
    chk("fill_acc9", acc[9] - acc[0], 102);
    wait_idle(1500);
    for (int i = 0; i < 10; i++) chk("fill_order", log_at(n0 + i), i);

    // Extremes 0x00 then 0xFF.
    n0 = dec_log.size();
    r0 = run_log.size();
    push_byte(8'h00, e);
    push_byte(8'hFF, e2);
    tx_valid = 1'b0;
    wait_idle(500);
    chk("ext_low_00", run_at(r0), 90);
    chk("ext_low_ff", run_at(r0 + 1), 10);
    chk("ext_runs", run_log.size() - r0, 2);
    chk("ext_dec0", log_at(n0), 'h00);
    chk("ext_dec1", log_at(n0 + 1), 'hFF);

    // Reset during data bit 3 of 0x0F with two bytes queued.
    n0 = dec_log.size();
    push_byte(8'h0F, e);
    push_byte(8'h11, e2);
    push_byte(8'h22, e2);
    tx_valid = 1'b0;
    wait_until(e + 45);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_txd", int'(uart_txd), 1);
    chk("mid_rst_level", int'(fifo_level), 0);
    chk("mid_rst_ready", int'(tx_ready), 1);
    chk("mid_rst_busy", int'(tx_busy), 0);
    repeat (3) @(negedge sys_clk);
    #2 sys_rst_n = 1'b1;
    @(negedge sys_clk);
    chk("mid_rst_no_partial", dec_log.size() - n0, 0);
    push_byte(8'h42, e);
    tx_valid = 1'b0;
    wait_idle(500);
    chk("mid_rst_count", dec_log.size() - n0, 1);
    chk("mid_rst_dec", log_at(n0), 'h42);

    // Refused pushes while full.
    n0 = dec_log.size();
    for (int i = 0; i < 9; i++) push_byte(8'(8'h61 + i), e);
    tx_data = 8'hEE;
    for (int k = 0; k < 5; k++) begin
      chk("refuse_ready", int'(tx_ready), 0);
      @(posedge sys_clk);
      @(negedge sys_clk);
    end
    tx_valid = 1'b0;
    wait_idle(1500);
    chk("refuse_count", dec_log.size() - n0, 9);
    for (int i = 0; i < 9; i++) chk("refuse_order", log_at(n0 + i), 'h61 + i);

    // Random traffic alternating bursty and sparse phases.
    for (int k = 0; k < 4000; k++) begin
      div      = ((k / 500) % 2 == 0) ? 1 : 150;
      tx_valid = ($urandom_range(0, div) == 0);
      tx_data  = 8'($urandom);
      @(posedge sys_clk);
      @(negedge sys_clk);
    end
    tx_valid = 1'b0;
    wait_idle(2000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_buf.md
# uart_tx_buf

Buffered UART transmitter, 8N1, LSB first: the transmit-side counterpart of the team's UART receiver on the same serial link. On-chip logic pushes bytes through a valid/ready handshake into a small FIFO. A bit-timing state machine drains the FIFO onto `uart_txd`, sending frames back-to-back while data is queued. Used by the debug/print path to emit characters to the host at a fixed baud rate.

## Interface
- `CLK_FREQ`, default 50000000: `sys_clk` frequency in Hz.
- `UART_BPS`, default 115200: baud rate.
- `FIFO_DEPTH`, default 8: FIFO entries; power of two, ≥2.
- `sys_clk`, in, 1: clock; all logic is on the rising edge.
- `sys_rst_n`, in, 1: reset, asynchronous, active-low.
- `tx_valid`, in, 1: `tx_data` is offered.
- `tx_data`, in, 8: byte to send.
- `tx_ready`, out, 1: FIFO can accept a byte; equals ~full; reset 1.
- `uart_txd`, out, 1: serial line, registered, idles high; reset 1.
- `tx_busy`, out, 1: FIFO is non-empty or the FSM is not in IDLE; reset 0.
- `fifo_level`, out, clog2(FIFO_DEPTH)+1: current FIFO occupancy; reset 0.

## Operation
- `BPS_CNT` = `CLK_FREQ`/`UART_BPS`, integer truncation. It must lie in 2..65535; elaboration fails otherwise.
- **Push:** a byte is accepted on a rising edge where `tx_valid` and `tx_ready` are both 1. While `tx_ready`=0, `tx_valid` is ignored and the offered byte is not stored; upstream must hold it.
- **Full FIFO:** a push is refused even if a pop happens on the same edge. `tx_ready` is a function of full only.
- **FSM states** are IDLE, START, DATA and STOP. `clk_cnt` is 16-bit and counts 0..`BPS_CNT`-1. `bit_idx` is 3-bit.
- IDLE → START when the FIFO is non-empty. This edge pops the head into the shift register, drives `uart_txd` to 0 and clears `clk_cnt`.
- START → DATA when `clk_cnt` = `BPS_CNT`-1. This edge drives `uart_txd` to shift[0] and clears `bit_idx`.
- DATA:
  - When `clk_cnt` = `BPS_CNT`-1 and `bit_idx` < 7: increment `bit_idx` and drive the next bit.
  - When `clk_cnt` = `BPS_CNT`-1 and `bit_idx` = 7: go to STOP and drive `uart_txd` to 1.
- STOP, when `clk_cnt` = `BPS_CNT`-1:
  - FIFO non-empty: pop, go to START and drive `uart_txd` to 0 on the same edge. There is no idle gap between frames.
  - FIFO empty: go to IDLE; `uart_txd` stays 1.
- **FIFO:** read and write pointers carry an extra wrap bit.
  - empty = pointers equal.
  - full = indices equal and wrap bits differ.
  - Pointers wrap modulo 2·`FIFO_DEPTH`.
  - A simultaneous push and pop leaves `fifo_level` unchanged.
- **Reset mid-operation:** asynchronous assertion immediately forces `uart_txd`=1, clears the FIFO, returns the FSM to IDLE and zeroes the counters. A partial frame is abandoned with no completion.

## Timing
- `uart_txd` falls on the first edge after the accepting edge, provided the FIFO was empty and the FSM was in IDLE.
- Each bit, including start and stop, lasts exactly `BPS_CNT` cycles. A frame is 10·`BPS_CNT` cycles.
- `tx_busy` falls on the edge that ends the last stop bit.
- `fifo_level` and `tx_ready` update on the edge after the push or pop, as registered-state-derived values.
- `tx_ready` depends only on registered state; there is no combinational path from `tx_valid`.

## Structure
- `uart_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, STOP);
  - `DATA_BITS`=8;
  - a `bps_cnt(clk_freq, bps)` function.
- The package is shared with the receiver.
- Sub-module `uart_tx_fifo` is a synchronous FIFO parameterised by width and depth. It exposes push, pop, wdata, rdata (first-word fall-through), full, empty and level.
- The top level contains the FSM, the shift register and the output register.

## Test plan
All directed tests use `CLK_FREQ`=1000000, `UART_BPS`=100000, giving `BPS_CNT`=10, with `FIFO_DEPTH`=8. A bench-side serial decoder samples at mid-bit.
- **Single byte:** push 0x55 at edge E.
  - `uart_txd` is low from E+1 for 10 cycles, then data bits 1,0,1,0,1,0,1,0, each for 10 cycles, then high.
  - `tx_busy` falls at E+101.
  - The decoder reads 0x55.
- **Back-to-back:** push 0xA5 and 0x3C on consecutive edges.
  - 200 contiguous frame cycles with no idle cycles between the stop bit and the second start bit.
  - The decoder reads 0xA5, then 0x3C.
- **Fill:** hold `tx_valid`=1 with bytes 0x00..0x09.
  - 9 bytes are accepted, because the first is popped on the edge after it is written.
  - `tx_ready` goes to 0 with `fifo_level`=8.
  - 0x09 is accepted on the edge after the STOP→START transition that pops 0x01.
  - All 10 bytes arrive in order.
- **Extremes:** push 0x00, then 0xFF.
  - 0x00: 90 low cycles, then a stop bit.
  - 0xFF: 10 low cycles, then 90 high.
- **Reset mid-frame:** assert `sys_rst_n`=0 during data bit 3 of 0x0F with two more bytes queued.
  - Immediately `uart_txd`=1, `fifo_level`=0, `tx_ready`=1 and `tx_busy`=0.
  - After release, a pushed 0x42 is decoded correctly.
- **Refused push:** with the FIFO full, drive `tx_valid`=1 with 0xEE for 5 cycles, then drop it. 0xEE never appears on the line.
